// File: rtl/sine_interpolator.sv
// Quarter-wave sine ROM lookup with sign folding and optional linear interpolation.
// Define NCO_INTERP_EN to enable the interpolation datapath; otherwise sample = signed lower sample.
module sine_interpolator #(
  parameter int unsigned LUT_Size  = 8,
  parameter int unsigned decimals  = 16,
  parameter int unsigned amp_width = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LUT_Size-1:0]         index_low,
  input  logic [LUT_Size-1:0]         index_high,
  input  logic [decimals-1:0]         index_decimals,
  input  logic                        sign_low,
  input  logic                        sign_high,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [amp_width-1:0] sample
);

  localparam int unsigned Depth = 1 << LUT_Size;
  // pi in Q60 fixed point
  localparam logic [127:0] PiQ60 = 128'h3243F6A8885A308D;

  // round((2**(amp_width-1)-1) * sin(pi/2*(idx+0.5)/Depth)) via a Q60 Taylor series
  function automatic logic [amp_width-1:0] sine_entry(input int unsigned idx);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc_pos;
    logic [127:0] acc_neg;
    logic [127:0] amp;
    x       = (PiQ60 * 128'(2 * idx + 1)) >> (LUT_Size + 2);
    x2      = (x * x) >> 60;
    term    = x;
    acc_pos = x;
    acc_neg = '0;
    for (int k = 1; k < 14; k++) begin
      term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
      if (k % 2 == 1) acc_neg = acc_neg + term;
      else            acc_pos = acc_pos + term;
    end
    amp = (128'(1) << (amp_width - 1)) - 128'(1);
    return amp_width'((((acc_pos - acc_neg) * amp) + (128'(1) << 59)) >> 60);
  endfunction

  logic [amp_width-1:0] rom [Depth];

  for (genvar gi = 0; gi < int'(Depth); gi++) begin : g_rom
    localparam logic [amp_width-1:0] Entry = sine_entry(gi);
    assign rom[gi] = Entry;
  end

  logic stall_c;
  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;

  logic                        v1, v2, v3, v4;
  logic [LUT_Size-1:0]         idx_lo1;
  logic                        sl1, sl2;
  logic [amp_width-1:0]        mag_lo2;
  logic signed [amp_width-1:0] lo3, lo4;
  logic signed [amp_width-1:0] lo_s_c;
  logic signed [amp_width-1:0] sum_c;

  // Lower-sample path and valid chain; every stage holds while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
      idx_lo1   <= '0;
      sl1       <= 1'b0;
      mag_lo2   <= '0;
      sl2       <= 1'b0;
      lo3       <= '0;
      lo4       <= '0;
      sample    <= '0;
    end else if (!stall_c) begin
      v1        <= in_valid;
      idx_lo1   <= index_low;
      sl1       <= sign_low;
      v2        <= v1;
      mag_lo2   <= rom[idx_lo1];
      sl2       <= sl1;
      v3        <= v2;
      lo3       <= lo_s_c;
      v4        <= v3;
      lo4       <= lo3;
      out_valid <= v4;
      sample    <= sum_c;
    end
  end

`ifdef NCO_INTERP_EN
  localparam int unsigned DiffW = amp_width + 1;
  localparam int unsigned ProdW = amp_width + 1 + decimals;
  localparam logic signed [ProdW-1:0] Half = ProdW'(64'd1 << (decimals - 1));

  logic [LUT_Size-1:0]         idx_hi1;
  logic                        sh1, sh2;
  logic [decimals-1:0]         frac1, frac2, frac3;
  logic [amp_width-1:0]        mag_hi2;
  logic signed [DiffW-1:0]     diff3;
  logic signed [ProdW-1:0]     prod4;
  logic signed [amp_width-1:0] hi_s_c;
  logic signed [DiffW-1:0]     diff_c;
  logic signed [ProdW-1:0]     prod_c;

  // Upper-sample, difference and product path
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_hi1 <= '0;
      sh1     <= 1'b0;
      frac1   <= '0;
      mag_hi2 <= '0;
      sh2     <= 1'b0;
      frac2   <= '0;
      diff3   <= '0;
      frac3   <= '0;
      prod4   <= '0;
    end else if (!stall_c) begin
      idx_hi1 <= index_high;
      sh1     <= sign_high;
      frac1   <= index_decimals;
      mag_hi2 <= rom[idx_hi1];
      sh2     <= sh1;
      frac2   <= frac1;
      diff3   <= diff_c;
      frac3   <= frac2;
      prod4   <= prod_c;
    end
  end
`else
  logic unused_c;
  assign unused_c = ^{index_high, sign_high, index_decimals};
`endif

  // Sign folding and round-half-up interpolation
  always_comb begin
    lo_s_c = sl2 ? -$signed(mag_lo2) : $signed(mag_lo2);
    sum_c  = lo4;
`ifdef NCO_INTERP_EN
    hi_s_c = sh2 ? -$signed(mag_hi2) : $signed(mag_hi2);
    diff_c = DiffW'(hi_s_c) - DiffW'(lo_s_c);
    prod_c = ProdW'(diff3 * $signed({1'b0, frac3}));
    sum_c  = lo4 + amp_width'((prod4 + Half) >>> decimals);
`endif
  end

endmodule
